// File: rtl/exec_mem_stage_pkg.sv
// Shared encodings for the execute/memory stage: ALU control codes,
// main-control ALUOp values and the R-type funct constants it decodes.
package exec_mem_stage_pkg;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_code_t;

   typedef enum logic [1:0] {
      ALUOP_MEM   = 2'b00,
      ALUOP_BR    = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_IMM   = 2'b11
   } alu_op_t;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/exec_mem_stage_alu_ctrl_decode.sv
// ALU control: maps ALUOp and the funct field to a 3-bit ALU function code.
module alu_ctrl_decode
   import exec_mem_stage_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] fn_field,
   output logic [2:0] alu_code
);

   always_comb begin
      alu_code = ALU_ADD;
      case (alu_op)
         ALUOP_MEM:  alu_code = ALU_ADD;
         ALUOP_BR:   alu_code = ALU_SUB;
         ALUOP_IMM:  alu_code = ALU_ADD;
         ALUOP_RTYPE: begin
            case (fn_field)
               FN_ADD:  alu_code = ALU_ADD;
               FN_SUB:  alu_code = ALU_SUB;
               FN_AND:  alu_code = ALU_AND;
               FN_OR:   alu_code = ALU_OR;
               FN_SLT:  alu_code = ALU_SLT;
               default: alu_code = ALU_ADD;
            endcase
         end
         default:    alu_code = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/exec_mem_stage.sv
// Combined execute/memory stage: ALU with operand-B select, a word-addressed
// data memory with combinational read, and the write-back select.
module exec_mem_stage
   import exec_mem_stage_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  alu_op,
   input  logic [5:0]  fn_field,
   input  logic        alu_src,
   input  logic [31:0] ra_data,
   input  logic [31:0] rb_data,
   input  logic [31:0] imm_ext,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   output logic [31:0] alu_out,
   output logic        zero,
   output logic        c_out,
   output logic [31:0] read_data,
   output logic [31:0] wb_data
);

   localparam int AW = $clog2(DEPTH);

   logic [2:0]    alu_code;
   logic [31:0]   op_b;
   logic [32:0]   sum;
   logic [AW-1:0] addr;
   logic [31:0]   mem [DEPTH];

   alu_ctrl_decode u_alu_ctrl_decode (
      .alu_op   (alu_op),
      .fn_field (fn_field),
      .alu_code (alu_code)
   );

   assign op_b = alu_src ? imm_ext : rb_data;

   // Subtraction reuses the adder as a + ~b + 1 so the carry means "no borrow".
   always_comb begin
      sum     = 33'd0;
      alu_out = 32'd0;
      c_out   = 1'b0;
      case (alu_code)
         ALU_AND: alu_out = ra_data & op_b;
         ALU_OR:  alu_out = ra_data | op_b;
         ALU_ADD: begin
            sum     = {1'b0, ra_data} + {1'b0, op_b};
            alu_out = sum[31:0];
            c_out   = sum[32];
         end
         ALU_SUB: begin
            sum     = {1'b0, ra_data} + {1'b0, ~op_b} + 33'd1;
            alu_out = sum[31:0];
            c_out   = sum[32];
         end
         ALU_SLT: alu_out = ($signed(ra_data) < $signed(op_b)) ? 32'd1 : 32'd0;
         default: begin
            alu_out = 32'd0;
            c_out   = 1'b0;
         end
      endcase
   end

   assign zero = (alu_out == 32'd0);

   // Upper address bits are dropped, so accesses wrap modulo DEPTH.
   assign addr = alu_out[AW-1:0];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         always_ff @(posedge clk) begin
            if (reset) begin
               mem[gi] <= 32'd0;
            end else if (mem_write && (addr == AW'(gi))) begin
               mem[gi] <= rb_data;
            end
         end
      end
   endgenerate

   assign read_data = mem_read ? mem[addr] : 32'd0;
   assign wb_data   = mem_to_reg ? read_data : alu_out;

endmodule

// File: tb/tb_exec_mem_stage.sv
// Directed self-checking bench for exec_mem_stage: ALU functions, store/load,
// address wrap, read-during-write, branch compare and reset clearing.
module tb_exec_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  alu_op;
   logic [5:0]  fn_field;
   logic        alu_src;
   logic [31:0] ra_data;
   logic [31:0] rb_data;
   logic [31:0] imm_ext;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic [31:0] alu_out;
   logic        zero;
   logic        c_out;
   logic [31:0] read_data;
   logic [31:0] wb_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   exec_mem_stage #(.DEPTH(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_op     (alu_op),
      .fn_field   (fn_field),
      .alu_src    (alu_src),
      .ra_data    (ra_data),
      .rb_data    (rb_data),
      .imm_ext    (imm_ext),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .alu_out    (alu_out),
      .zero       (zero),
      .c_out      (c_out),
      .read_data  (read_data),
      .wb_data    (wb_data)
   );

   // Drive a memory address through the ALU: alu_op=00, ra=addr, imm=0.
   task automatic set_addr(input logic [31:0] a);
      alu_op   = 2'b00;
      fn_field = 6'b000000;
      alu_src  = 1'b1;
      ra_data  = a;
      imm_ext  = 32'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_write = 1'b0; mem_read = 1'b1; mem_to_reg = 1'b1;
      rb_data = 32'd0;
      set_addr(32'd0);
      tick(); tick();
      reset = 1'b0;
      #1;
      if (read_data !== 32'd0) begin
         $display("FAIL reset_addr0 got=%h want=%h", read_data, 32'd0); bad++;
      end
      total++;
      set_addr(32'd63); #1;
      if (wb_data !== 32'd0) begin
         $display("FAIL reset_addr63 got=%h want=%h", wb_data, 32'd0); bad++;
      end
      total++;
      $display("test_reset done");
   endtask

   task automatic test_alu();
      alu_op = 2'b10; alu_src = 1'b0; mem_to_reg = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      imm_ext = 32'd0;
      fn_field = 6'b100010; ra_data = 32'd7; rb_data = 32'd5; #1;
      if (alu_out !== 32'd2 || zero !== 1'b0 || c_out !== 1'b1 || wb_data !== 32'd2) begin
         $display("FAIL sub_7_5 got=%h z=%b c=%b wb=%h want=2 z=0 c=1 wb=2", alu_out, zero, c_out, wb_data); bad++;
      end
      total++;
      fn_field = 6'b101010; ra_data = 32'hFFFF_FFFF; rb_data = 32'd1; #1;
      if (alu_out !== 32'd1 || c_out !== 1'b0) begin
         $display("FAIL slt_neg got=%h c=%b want=1 c=0", alu_out, c_out); bad++;
      end
      total++;
      ra_data = 32'd1; rb_data = 32'hFFFF_FFFF; #1;
      if (alu_out !== 32'd0 || zero !== 1'b1) begin
         $display("FAIL slt_swap got=%h z=%b want=0 z=1", alu_out, zero); bad++;
      end
      total++;
      fn_field = 6'b100000; ra_data = 32'hFFFF_FFFF; rb_data = 32'd1; #1;
      if (alu_out !== 32'd0 || zero !== 1'b1 || c_out !== 1'b1) begin
         $display("FAIL add_wrap got=%h z=%b c=%b want=0 z=1 c=1", alu_out, zero, c_out); bad++;
      end
      total++;
      fn_field = 6'b100100; ra_data = 32'h0000_F0F0; rb_data = 32'h0000_0FF0; #1;
      if (alu_out !== 32'h0000_00F0 || c_out !== 1'b0) begin
         $display("FAIL and got=%h c=%b want=000000f0 c=0", alu_out, c_out); bad++;
      end
      total++;
      fn_field = 6'b100101; #1;
      if (alu_out !== 32'h0000_FFF0 || c_out !== 1'b0) begin
         $display("FAIL or got=%h c=%b want=0000fff0 c=0", alu_out, c_out); bad++;
      end
      total++;
      // Unknown funct falls back to ADD; immediate operand selected.
      fn_field = 6'b111111; alu_src = 1'b1; imm_ext = 32'd100; rb_data = 32'd9; ra_data = 32'd23; #1;
      if (alu_out !== 32'd123) begin
         $display("FAIL default_add_imm got=%h want=%h", alu_out, 32'd123); bad++;
      end
      total++;
      $display("test_alu done");
   endtask

   task automatic test_store_load();
      alu_op = 2'b00; alu_src = 1'b1; fn_field = 6'b000000;
      ra_data = 32'd8; imm_ext = 32'd4; rb_data = 32'hDEAD_BEEF;
      mem_write = 1'b1; mem_read = 1'b0; mem_to_reg = 1'b0;
      tick();
      mem_write = 1'b0; mem_read = 1'b1; mem_to_reg = 1'b1; rb_data = 32'd0; #1;
      if (read_data !== 32'hDEAD_BEEF || wb_data !== 32'hDEAD_BEEF) begin
         $display("FAIL load12 rd=%h wb=%h want=deadbeef", read_data, wb_data); bad++;
      end
      total++;
      mem_read = 1'b0; #1;
      if (read_data !== 32'd0) begin
         $display("FAIL load_disabled got=%h want=0", read_data); bad++;
      end
      total++;
      $display("test_store_load done");
   endtask

   task automatic test_wrap();
      set_addr(32'd70);
      rb_data = 32'h1111_2222; mem_write = 1'b1; mem_read = 1'b0; mem_to_reg = 1'b1;
      tick();
      mem_write = 1'b0; mem_read = 1'b1; set_addr(32'd6); #1;
      if (read_data !== 32'h1111_2222) begin
         $display("FAIL wrap_read6 got=%h want=11112222", read_data); bad++;
      end
      total++;
      rb_data = 32'h3333_4444; mem_write = 1'b1; #1;
      if (read_data !== 32'h1111_2222) begin
         $display("FAIL rdw_old got=%h want=11112222", read_data); bad++;
      end
      total++;
      tick();
      mem_write = 1'b0; #1;
      if (read_data !== 32'h3333_4444) begin
         $display("FAIL rdw_new got=%h want=33334444", read_data); bad++;
      end
      total++;
      $display("test_wrap done");
   endtask

   task automatic test_branch();
      alu_op = 2'b01; alu_src = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
      ra_data = 32'd42; rb_data = 32'd42; #1;
      if (zero !== 1'b1 || c_out !== 1'b1) begin
         $display("FAIL beq_equal z=%b c=%b want z=1 c=1", zero, c_out); bad++;
      end
      total++;
      rb_data = 32'd43; #1;
      if (zero !== 1'b0 || alu_out !== 32'hFFFF_FFFF || c_out !== 1'b0) begin
         $display("FAIL beq_diff z=%b out=%h c=%b want z=0 out=ffffffff c=0", zero, alu_out, c_out); bad++;
      end
      total++;
      $display("test_branch done");
   endtask

   task automatic test_reset_clear();
      mem_read = 1'b0; mem_to_reg = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         set_addr(32'(i));
         rb_data = 32'hA000_0000 + 32'(i); mem_write = 1'b1;
         tick();
      end
      mem_write = 1'b0; mem_read = 1'b1; set_addr(32'd2); #1;
      if (read_data !== 32'hA000_0002) begin
         $display("FAIL prefill2 got=%h want=a0000002", read_data); bad++;
      end
      total++;
      set_addr(32'd5); rb_data = 32'h5555_5555; mem_write = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; mem_write = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         set_addr(32'(i)); #1;
         if (read_data !== 32'd0) begin
            $display("FAIL reset_clear addr=%0d got=%h want=0", i, read_data); bad++;
         end
         total++;
      end
      set_addr(32'd12); #1;
      if (wb_data !== 32'd0) begin
         $display("FAIL reset_clear addr=12 got=%h want=0", wb_data); bad++;
      end
      total++;
      $display("test_reset_clear done");
   endtask

   initial begin
      reset = 1'b1; alu_op = 2'b00; fn_field = 6'd0; alu_src = 1'b0;
      ra_data = 32'd0; rb_data = 32'd0; imm_ext = 32'd0;
      mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
      test_reset();
      test_alu();
      test_store_load();
      test_wrap();
      test_branch();
      test_reset_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
